// File: rtl/gate_resp_checker_if.sv
// Stimulus-side bundle between a gate bench and gate_resp_checker:
// the run control (start/op_sel) and the sampled vector with the gate's response.
interface gate_resp_checker_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [2:0]      op_sel;
  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            dut_y;

  modport master (output start, op_sel, in_valid, in_vec, dut_y);
  modport slave  (input  start, op_sel, in_valid, in_vec, dut_y);
endinterface

// File: rtl/gate_resp_checker.sv
// Response checker for logic-gate benches: checks dut_y against the latched function and tracks input coverage.
// Optional: define GATE_CHK_HALT_ON_ERR_EN to end a run at the first mismatch.
module gate_resp_checker #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gate_resp_checker_if.slave     stim,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       vec_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [(1<<N_IN)-1:0]   cov_map,
  output logic                   first_fail_valid,
  output logic [N_IN-1:0]        first_fail_vec,
  output logic                   first_fail_y
);

  localparam int COV_W = 1 << N_IN;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [COV_W-1:0] COV_ZERO = {COV_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Expected gate output for the latched op; NOT/BUF look only at bit 0.
  function automatic logic calc_exp(input logic [2:0] op, input logic [N_IN-1:0] v);
    logic r;
    r = 1'b0;
    case (op)
      3'd0:    r = &v;
      3'd1:    r = |v;
      3'd2:    r = ~&v;
      3'd3:    r = ~|v;
      3'd4:    r = ^v;
      3'd5:    r = ~^v;
      3'd6:    r = ~v[0];
      3'd7:    r = v[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [2:0]       op_r, op_s;
  logic [CNT_W-1:0] vec_r, vec_s;
  logic [CNT_W-1:0] err_r, err_s;
  logic [COV_W-1:0] cov_r, cov_s;
  logic             ffv_r, ffv_s;
  logic [N_IN-1:0]  ffvec_r, ffvec_s;
  logic             ffy_r, ffy_s;
  logic             busy_r, done_r, pass_r;
  logic             exp_s, mism_s;

  // Next-state and result update; start restarts from any state and drops a coincident sample.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    vec_s   = vec_r;
    err_s   = err_r;
    cov_s   = cov_r;
    ffv_s   = ffv_r;
    ffvec_s = ffvec_r;
    ffy_s   = ffy_r;
    exp_s   = calc_exp(op_r, stim.in_vec);
    mism_s  = (stim.dut_y != exp_s);

    if (stim.start) begin
      state_s = ST_CHECK;
      op_s    = stim.op_sel;
      vec_s   = CNT_ZERO;
      err_s   = CNT_ZERO;
      cov_s   = COV_ZERO;
      ffv_s   = 1'b0;
      ffvec_s = {N_IN{1'b0}};
      ffy_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_CHECK: begin
          if (stim.in_valid) begin
            if (vec_r != CNT_MAX) begin
              vec_s = vec_r + CNT_ONE;
            end else begin
              vec_s = vec_r;
            end
            cov_s[stim.in_vec] = 1'b1;
            if (mism_s) begin
              if (err_r != CNT_MAX) begin
                err_s = err_r + CNT_ONE;
              end else begin
                err_s = err_r;
              end
              if (!ffv_r) begin
                ffv_s   = 1'b1;
                ffvec_s = stim.in_vec;
                ffy_s   = stim.dut_y;
              end else begin
                ffv_s   = ffv_r;
              end
            end else begin
              err_s = err_r;
            end
`ifdef GATE_CHK_HALT_ON_ERR_EN
            if (mism_s || (&cov_s)) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_CHECK;
            end
`else
            if (&cov_s) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_CHECK;
            end
`endif
          end else begin
            state_s = ST_CHECK;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and result registers; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= 3'd0;
      vec_r   <= CNT_ZERO;
      err_r   <= CNT_ZERO;
      cov_r   <= COV_ZERO;
      ffv_r   <= 1'b0;
      ffvec_r <= {N_IN{1'b0}};
      ffy_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      vec_r   <= vec_s;
      err_r   <= err_s;
      cov_r   <= cov_s;
      ffv_r   <= ffv_s;
      ffvec_r <= ffvec_s;
      ffy_r   <= ffy_s;
      busy_r  <= (state_s == ST_CHECK);
      done_r  <= (state_s == ST_DONE);
      pass_r  <= (state_s == ST_DONE) && (err_s == CNT_ZERO);
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign vec_cnt          = vec_r;
  assign err_cnt          = err_r;
  assign cov_map          = cov_r;
  assign first_fail_valid = ffv_r;
  assign first_fail_vec   = ffvec_r;
  assign first_fail_y     = ffy_r;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: a counting-based reference model checks two instances
// (CNT_W=8 and CNT_W=3) every cycle, plus literal checks from hand-worked scenarios.
module tb_gate_resp_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_resp_checker_if #(.N_IN(2)) bus ();

  logic       a_busy, a_done, a_pass, a_ffv, a_ffy;
  logic [7:0] a_vec, a_err;
  logic [3:0] a_cov;
  logic [1:0] a_ffvec;
  logic       b_busy, b_done, b_pass, b_ffv, b_ffy;
  logic [2:0] b_vec, b_err;
  logic [3:0] b_cov;
  logic [1:0] b_ffvec;

  gate_resp_checker #(.N_IN(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .stim(bus),
    .busy(a_busy), .done(a_done), .pass(a_pass), .vec_cnt(a_vec), .err_cnt(a_err),
    .cov_map(a_cov), .first_fail_valid(a_ffv), .first_fail_vec(a_ffvec), .first_fail_y(a_ffy)
  );

  gate_resp_checker #(.N_IN(2), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .stim(bus),
    .busy(b_busy), .done(b_done), .pass(b_pass), .vec_cnt(b_vec), .err_cnt(b_err),
    .cov_map(b_cov), .first_fail_valid(b_ffv), .first_fail_vec(b_ffvec), .first_fail_y(b_ffy)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Reference model: phase 0=idle 1=check 2=done, coverage as an integer bitmask.
  int   m_phase [2] = '{0, 0};
  int   m_op    [2] = '{0, 0};
  int   m_vec   [2] = '{0, 0};
  int   m_err   [2] = '{0, 0};
  int   m_cov   [2] = '{0, 0};
  int   m_ffv   [2] = '{0, 0};
  int   m_ffvec [2] = '{0, 0};
  int   m_ffy   [2] = '{0, 0};
  int   m_max   [2] = '{255, 7};

  function automatic logic model_exp(input int op, input int v);
    int ones;
    ones = (v & 1) + ((v >> 1) & 1);
    case (op)
      0: return ones == 2;
      1: return ones > 0;
      2: return ones != 2;
      3: return ones == 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      6: return (v & 1) == 0;
      default: return (v & 1) == 1;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] = 0; m_op[i] = 0; m_vec[i] = 0; m_err[i] = 0;
        m_cov[i] = 0; m_ffv[i] = 0; m_ffvec[i] = 0; m_ffy[i] = 0;
      end else if (bus.start) begin
        m_phase[i] = 1; m_op[i] = int'(bus.op_sel); m_vec[i] = 0; m_err[i] = 0;
        m_cov[i] = 0; m_ffv[i] = 0; m_ffvec[i] = 0; m_ffy[i] = 0;
      end else if (m_phase[i] == 1 && bus.in_valid) begin
        logic bad;
        bad = (bus.dut_y !== model_exp(m_op[i], int'(bus.in_vec)));
        if (m_vec[i] < m_max[i]) m_vec[i]++;
        m_cov[i] = m_cov[i] | (1 << bus.in_vec);
        if (bad) begin
          if (m_err[i] < m_max[i]) m_err[i]++;
          if (m_ffv[i] == 0) begin
            m_ffv[i] = 1; m_ffvec[i] = int'(bus.in_vec); m_ffy[i] = int'(bus.dut_y);
          end
`ifdef GATE_CHK_HALT_ON_ERR_EN
          m_phase[i] = 2;
`endif
        end
        if (m_cov[i] == 15) m_phase[i] = 2;
      end
    end
  end

  task automatic cmp_inst(input int i, input logic busy, input logic done, input logic pass,
                          input logic [7:0] vec, input logic [7:0] err, input logic [3:0] cov,
                          input logic ffv, input logic [1:0] ffvec, input logic ffy);
    chk("busy", i, busy, m_phase[i] == 1);
    chk("done", i, done, m_phase[i] == 2);
    chk("pass", i, pass, (m_phase[i] == 2) && (m_err[i] == 0));
    chk("vec_cnt", i, vec, m_vec[i]);
    chk("err_cnt", i, err, m_err[i]);
    chk("cov_map", i, cov, m_cov[i]);
    chk("ff_valid", i, ffv, m_ffv[i]);
    chk("ff_vec", i, ffvec, m_ffvec[i]);
    chk("ff_y", i, ffy, m_ffy[i]);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, a_busy, a_done, a_pass, a_vec, a_err, a_cov, a_ffv, a_ffvec, a_ffy);
      cmp_inst(1, b_busy, b_done, b_pass, {5'd0, b_vec}, {5'd0, b_err}, b_cov, b_ffv, b_ffvec, b_ffy);
    end
  end

  // One clock of stimulus; returns 2 time units after the edge that consumed it.
  task automatic cyc(input logic s, input logic [2:0] op, input logic v,
                     input logic [1:0] vec, input logic y);
    bus.start = s; bus.op_sel = op; bus.in_valid = v; bus.in_vec = vec; bus.dut_y = y;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic send(input logic [1:0] vec, input logic y);
    cyc(1'b0, 3'd0, 1'b1, vec, y);
  endtask

  task automatic go(input logic [2:0] op);
    cyc(1'b1, op, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op_sel = 3'd0; bus.in_valid = 1'b0; bus.in_vec = 2'd0; bus.dut_y = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #2;
    idle();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", 0, a_busy, 1'b0);
    chk("rst_done", 0, a_done, 1'b0);
    chk("rst_vec", 0, a_vec, 8'd0);
    chk("rst_cov", 0, a_cov, 4'd0);

    // AND exhaustive, correct, with one idle gap
    go(3'd0);
    send(2'd0, 1'b0); send(2'd1, 1'b0); idle(); send(2'd2, 1'b0); send(2'd3, 1'b1);
    chk("and_done", 0, a_done, 1'b1);
    chk("and_pass", 0, a_pass, 1'b1);
    chk("and_vec", 0, a_vec, 8'd4);
    chk("and_err", 0, a_err, 8'd0);
    chk("and_cov", 0, a_cov, 4'b1111);
    chk("and_busy", 0, a_busy, 1'b0);
    idle();

    // Single fault on 01
    go(3'd0);
    send(2'd0, 1'b0); send(2'd1, 1'b1); send(2'd2, 1'b0); send(2'd3, 1'b1);
    chk("flt_done", 0, a_done, 1'b1);
    chk("flt_pass", 0, a_pass, 1'b0);
    chk("flt_err", 0, a_err, 8'd1);
    chk("flt_ffv", 0, a_ffv, 1'b1);
    chk("flt_ffvec", 0, a_ffvec, 2'b01);
    chk("flt_ffy", 0, a_ffy, 1'b1);
`ifndef GATE_CHK_HALT_ON_ERR_EN
    chk("flt_vec", 0, a_vec, 8'd4);
`endif

    // XOR with repeats; done only after 01
    go(3'd4);
    send(2'd3, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0); send(2'd2, 1'b1);
    chk("xor_notdone", 0, a_done, 1'b0);
    send(2'd1, 1'b1);
    chk("xor_done", 0, a_done, 1'b1);
    chk("xor_vec", 0, a_vec, 8'd5);
    chk("xor_err", 0, a_err, 8'd0);

    // Restart mid-run as OR; simultaneous sample is dropped
    go(3'd3);
    send(2'd0, 1'b1); send(2'd1, 1'b0);
    cyc(1'b1, 3'd1, 1'b1, 2'd3, 1'b1);
    chk("rs_vec", 0, a_vec, 8'd0);
    chk("rs_cov", 0, a_cov, 4'd0);
    chk("rs_busy", 0, a_busy, 1'b1);
    send(2'd3, 1'b1);
    chk("rs_or_err", 0, a_err, 8'd0);
    chk("rs_or_vec", 0, a_vec, 8'd1);

    // Reset mid-run, then in_valid ignored in IDLE
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    chk("mr_busy", 0, a_busy, 1'b0);
    chk("mr_vec", 0, a_vec, 8'd0);
    chk("mr_cov", 0, a_cov, 4'd0);
    send(2'd2, 1'b0);
    chk("idle_vec", 0, a_vec, 8'd0);
    chk("idle_busy", 0, a_busy, 1'b0);

    // Saturation: ten wrong AND samples on 00/01/10, then a wrong 11
    go(3'd0);
    for (int k = 0; k < 10; k++) send(2'(k % 3), 1'b1);
    chk("sat_notdone", 1, b_done, 1'b0 | b_ffv & 1'b0 | (b_done & 1'b0) | 1'b0);
    send(2'd3, 1'b0);
`ifndef GATE_CHK_HALT_ON_ERR_EN
    chk("sat_err", 1, b_err, 3'd7);
    chk("sat_vec", 1, b_vec, 3'd7);
    chk("sat_done", 1, b_done, 1'b1);
    chk("sat_wide_err", 0, a_err, 8'd11);
`endif

`ifdef GATE_CHK_HALT_ON_ERR_EN
    // Halt on first NAND mismatch
    go(3'd2);
    send(2'd0, 1'b0);
    chk("halt_done", 0, a_done, 1'b1);
    chk("halt_pass", 0, a_pass, 1'b0);
    chk("halt_err", 0, a_err, 8'd1);
    chk("halt_vec", 0, a_vec, 8'd1);
    send(2'd1, 1'b0); send(2'd3, 1'b1);
    chk("halt_hold_vec", 0, a_vec, 8'd1);
    chk("halt_hold_cov", 0, a_cov, 4'b0001);
`endif

    idle(); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
